// File: rtl/iter_div_32_pkg.sv
// ============================================================================
//  Module   : iter_div_32_pkg
//  Brief    : Shared state encodings and constants for the iterative divider.
//             Optional signed support is enabled by ITER_DIV_SIGNED_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package iter_div_32_pkg;

    localparam int DIV_DATA_WIDTH = 32;
    localparam int DIV_ITER_COUNT = DIV_DATA_WIDTH;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_RUN  = 2'd1,
        DIV_ST_DONE = 2'd2,
        DIV_ST_FIX  = 2'd3
    } div_state_t;

`ifdef ITER_DIV_SIGNED_EN
    // Sign-fix of the remainder, needed in the same cycle the subtractor negates the quotient
    function automatic logic [DIV_DATA_WIDTH-1:0] twos_neg(input logic [DIV_DATA_WIDTH-1:0] v);
        return ~v + DIV_DATA_WIDTH'(1);
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/iter_div_32_rc_add_sub.sv
// ============================================================================
//  Module   : iter_div_32_rc_add_sub
//  Brief    : 32-bit ripple-carry adder/subtractor (SnA=1 subtracts, CO=1 on
//             subtraction means no borrow).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module iter_div_32_rc_add_sub (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        SnA,
    output logic [31:0] Y,
    output logic        CO
);

    logic [32:0] w_carry;
    logic [31:0] w_b_x;

    assign w_carry[0] = SnA;
    assign w_b_x      = B ^ {32{SnA}};

    genvar i;
    generate
        for (i = 0; i < 32; i = i + 1) begin : g_fa
            assign Y[i]         = A[i] ^ w_b_x[i] ^ w_carry[i];
            assign w_carry[i+1] = (A[i] & w_b_x[i]) | (w_carry[i] & (A[i] ^ w_b_x[i]));
        end
    endgenerate

    assign CO = w_carry[32];

endmodule

`default_nettype wire

// File: rtl/iter_div_32.sv
// ============================================================================
//  Module   : iter_div_32
//  Brief    : Multi-cycle restoring divider, one quotient bit per clock through
//             a single shared subtractor. Macro ITER_DIV_SIGNED_EN adds SIGNED.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module iter_div_32
    import iter_div_32_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
`ifdef ITER_DIV_SIGNED_EN
    input  logic                  SIGNED,
`endif
    input  logic [DATA_WIDTH-1:0] DIVIDEND,
    input  logic [DATA_WIDTH-1:0] DIVISOR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] QUOTIENT,
    output logic [DATA_WIDTH-1:0] REMAINDER,
    output logic                  DIV_ZERO
);

    div_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  dz_q, dz_d;

    logic [DATA_WIDTH-1:0] sub_a, sub_b, sub_y;
    logic                  sub_co;
    logic                  shift_out;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  success;
    logic                  load_phase;
    logic                  fix_needed;

`ifdef ITER_DIV_SIGNED_EN
    logic [1:0] ld_q, ld_d;
    logic       sgn_q, sgn_d;
    logic       qneg_q, qneg_d;
    logic       rneg_q, rneg_d;

    assign load_phase = (ld_q != 2'd0);
    assign fix_needed = sgn_q;
`else
    assign load_phase = 1'b0;
    assign fix_needed = 1'b0;
`endif

    assign shift_out = r_q[DATA_WIDTH-1];
    assign r_shift   = {r_q[DATA_WIDTH-2:0], q_q[DATA_WIDTH-1]};
    // The bit shifted out of R makes the partial remainder exceed D regardless of CO
    assign success   = sub_co | shift_out;

    iter_div_32_rc_add_sub u_sub (
        .A   (sub_a),
        .B   (sub_b),
        .SnA (1'b1),
        .Y   (sub_y),
        .CO  (sub_co)
    );

    always_comb begin
        sub_a = r_shift;
        sub_b = dvs_q;
`ifdef ITER_DIV_SIGNED_EN
        if (state_q == DIV_ST_RUN && load_phase) begin
            sub_a = '0;
            sub_b = (ld_q == 2'd2) ? q_q : dvs_q;
        end else if (state_q == DIV_ST_FIX) begin
            sub_a = '0;
            sub_b = q_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        q_d     = q_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef ITER_DIV_SIGNED_EN
        ld_d    = ld_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            DIV_ST_IDLE, DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
                if (START) begin
                    if (DIVISOR == '0) begin
                        quo_d   = '1;
                        rem_d   = DIVIDEND;
                        dz_d    = 1'b1;
                        state_d = DIV_ST_DONE;
                    end else begin
                        dvs_d   = DIVISOR;
                        q_d     = DIVIDEND;
                        r_d     = '0;
                        cnt_d   = CNT_WIDTH'(DIV_ITER_COUNT);
                        state_d = DIV_ST_RUN;
`ifdef ITER_DIV_SIGNED_EN
                        ld_d    = SIGNED ? 2'd2 : 2'd0;
                        sgn_d   = SIGNED;
                        qneg_d  = SIGNED & (DIVIDEND[DATA_WIDTH-1] ^ DIVISOR[DATA_WIDTH-1]);
                        rneg_d  = SIGNED & DIVIDEND[DATA_WIDTH-1];
`endif
                    end
                end
            end
            DIV_ST_RUN: begin
                if (load_phase) begin
`ifdef ITER_DIV_SIGNED_EN
                    if (ld_q == 2'd2 && q_q[DATA_WIDTH-1])
                        q_d = sub_y;
                    if (ld_q == 2'd1 && dvs_q[DATA_WIDTH-1])
                        dvs_d = sub_y;
                    ld_d = ld_q - 2'd1;
`endif
                end else begin
                    r_d   = success ? sub_y : r_shift;
                    q_d   = {q_q[DATA_WIDTH-2:0], success};
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        if (fix_needed) begin
                            state_d = DIV_ST_FIX;
                        end else begin
                            quo_d   = q_d;
                            rem_d   = r_d;
                            dz_d    = 1'b0;
                            state_d = DIV_ST_DONE;
                        end
                    end
                end
            end
            DIV_ST_FIX: begin
`ifdef ITER_DIV_SIGNED_EN
                quo_d = qneg_q ? sub_y : q_q;
                rem_d = rneg_q ? twos_neg(r_q) : r_q;
                dz_d  = 1'b0;
`endif
                state_d = DIV_ST_DONE;
            end
            default: state_d = DIV_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
`ifdef ITER_DIV_SIGNED_EN
            ld_q    <= 2'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            q_q     <= q_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef ITER_DIV_SIGNED_EN
            ld_q    <= ld_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign BUSY      = (state_q == DIV_ST_RUN) || (state_q == DIV_ST_FIX);
    assign DONE      = (state_q == DIV_ST_DONE);
    assign QUOTIENT  = quo_q;
    assign REMAINDER = rem_q;
    assign DIV_ZERO  = dz_q;

endmodule

`default_nettype wire
